// File: rtl/reg_read_scoreboard.sv
// reg_read_scoreboard: register busy-mask scoreboard for an in-order issue stage.
// It tracks which architectural registers have a write in flight and gates issue
// on RAW/WAW hazards and on a limit of eight outstanding writes. A writeback in the
// same cycle bypasses the busy bit.
// Optional feature macro: STALL_CNT_EN adds a saturating 16-bit stall_count output.
module reg_read_scoreboard (
  input  logic        clk,
  input  logic        ctrl_reset_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        rd_we,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  output logic [31:0] pending,
  output logic [3:0]  outstanding,
  output logic        wb_err
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [3:0] MAX_OUTSTANDING = 4'd8;

  logic [31:0] pending_q, pending_d;
  logic [3:0]  outstanding_q, outstanding_d;
  logic        wb_err_q, wb_err_d;

  logic        wb_clear;
  logic        raw_hazard;
  logic        waw_hazard;
  logic        full_block;
  logic        fire_set;

  // A register is effectively busy only if it is pending and is not being written back now.
  function automatic logic eff_busy(input logic [31:0] pend, input logic [4:0] idx,
                                    input logic wv, input logic [4:0] wr);
    logic b;
    b = (idx != 5'd0) && pend[idx] && !(wv && (wr == idx));
    return b;
  endfunction

  // Hazard detection and issue gating; issue_ready ignores issue_valid.
  always_comb begin
    wb_clear    = wb_valid && (wb_rd != 5'd0) && pending_q[wb_rd];
    raw_hazard  = eff_busy(pending_q, rs1, wb_valid, wb_rd) ||
                  eff_busy(pending_q, rs2, wb_valid, wb_rd);
    waw_hazard  = rd_we && eff_busy(pending_q, rd, wb_valid, wb_rd);
    full_block  = (outstanding_q == MAX_OUTSTANDING) && !wb_clear;
    issue_ready = ctrl_reset_n && !raw_hazard && !waw_hazard && !full_block;
    fire_set    = issue_valid && issue_ready && rd_we && (rd != 5'd0);
  end

  // Next-state for busy mask, write counter and error flag; a set beats a same-index clear.
  always_comb begin
    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    wb_err_d      = wb_err_q;
    if (wb_clear) begin
      pending_d[wb_rd] = 1'b0;
    end
    if (fire_set) begin
      pending_d[rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
    if (fire_set && !wb_clear) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (!fire_set && wb_clear) begin
      outstanding_d = outstanding_q - 4'd1;
    end
    if (wb_valid && !wb_clear) begin
      wb_err_d = 1'b1;
    end
  end

  // Scoreboard state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!ctrl_reset_n) begin
      pending_q     <= 32'h0;
      outstanding_q <= 4'd0;
      wb_err_q      <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign pending     = pending_q;
  assign outstanding = outstanding_q;
  assign wb_err      = wb_err_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Count cycles where an instruction is presented but cannot issue, saturating at max.
  always_comb begin
    stall_count_d = stall_count_q;
    if (issue_valid && !issue_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (!ctrl_reset_n) begin
      stall_count_q <= 16'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_reg_read_scoreboard.sv
// Testbench for reg_read_scoreboard: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural scoreboard model.
module tb_reg_read_scoreboard;

  logic        clk;
  logic        ctrl_reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic        rd_we, wb_valid;
  logic [31:0] pending;
  logic [3:0]  outstanding;
  logic        wb_err;
`ifdef STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  reg_read_scoreboard dut (
    .clk          (clk),
    .ctrl_reset_n (ctrl_reset_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .rd_we        (rd_we),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .pending      (pending),
    .outstanding  (outstanding),
    .wb_err       (wb_err)
`ifdef STALL_CNT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: set of busy registers, sticky error, stall counter.
  bit          busy_m [32];
  bit          err_m;
  int unsigned stall_m;
  logic        last_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int busy_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (busy_m[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = busy_m[i];
    return v;
  endfunction

  // Is register n blocked for an instruction this cycle (writeback bypass honoured)?
  function automatic bit blocked(input logic [4:0] n);
    if (n == 0) return 0;
    if (!busy_m[n]) return 0;
    if (wb_valid && wb_rd == n) return 0;
    return 1;
  endfunction

  function automatic bit model_ready();
    bit retiring;
    if (!ctrl_reset_n) return 0;
    retiring = wb_valid && (wb_rd != 0) && busy_m[wb_rd];
    if (blocked(rs1) || blocked(rs2)) return 0;
    if (rd_we && blocked(rd)) return 0;
    if (busy_count() == 8 && !retiring) return 0;
    return 1;
  endfunction

  task automatic model_clock(input bit rdy);
    bit retiring;
    if (!ctrl_reset_n) begin
      for (int i = 0; i < 32; i++) busy_m[i] = 0;
      err_m   = 0;
      stall_m = 0;
      return;
    end
    retiring = wb_valid && (wb_rd != 0) && busy_m[wb_rd];
    if (issue_valid && !rdy && stall_m < 16'hFFFF) stall_m++;
    if (wb_valid) begin
      if (retiring) busy_m[wb_rd] = 0;
      else err_m = 1;
    end
    if (issue_valid && rdy && rd_we && rd != 0) busy_m[rd] = 1;
  endtask

  // One clock: apply inputs, check issue_ready, clock, check registered outputs.
  task automatic step(input bit v, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input bit we, input bit wv,
                      input logic [4:0] wr, input bit rn);
    bit exp_rdy;
    issue_valid  = v;
    rs1          = a;
    rs2          = b;
    rd           = d;
    rd_we        = we;
    wb_valid     = wv;
    wb_rd        = wr;
    ctrl_reset_n = rn;
    #1;
    exp_rdy  = model_ready();
    last_rdy = issue_ready;
    check("issue_ready", {31'b0, issue_ready}, {31'b0, exp_rdy});
    @(posedge clk);
    model_clock(exp_rdy);
    @(negedge clk);
    check("pending", pending, busy_vec());
    check("outstanding", {28'b0, outstanding}, busy_count());
    check("wb_err", {31'b0, wb_err}, {31'b0, err_m});
`ifdef STALL_CNT_EN
    check("stall_count", {16'b0, stall_count}, stall_m);
`endif
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pending", pending, 32'h0);
    check("rst_outstanding", {28'b0, outstanding}, 32'd0);
    check("rst_wb_err", {31'b0, wb_err}, 32'd0);
  endtask

  initial begin
    issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_we = 0;
    wb_valid = 0; wb_rd = 0; ctrl_reset_n = 0;
    for (int i = 0; i < 32; i++) busy_m[i] = 0;
    err_m = 0; stall_m = 0;
    @(negedge clk);

    // Reset holds issue_ready low.
    do_reset();
    check("rst_ready_low", {31'b0, last_rdy}, 32'd0);

    // RAW hazard after a write to r5.
    step(1, 0, 0, 5, 1, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0, 0, 1);
    check("raw_ready", {31'b0, last_rdy}, 32'd0);
    check("raw_pending", pending, 32'h20);
    check("raw_outstanding", {28'b0, outstanding}, 32'd1);

    // Same-cycle writeback bypass on rs2.
    step(1, 0, 5, 0, 0, 1, 5, 1);
    check("bypass_ready", {31'b0, last_rdy}, 32'd1);
    check("bypass_pending", pending, 32'h0);

    // Fill eight writes, ninth blocks, then issues alongside a retiring writeback.
    for (int r = 1; r <= 8; r++) step(1, 0, 0, r[4:0], 1, 0, 0, 1);
    check("full_outstanding", {28'b0, outstanding}, 32'd8);
    step(1, 0, 0, 9, 1, 0, 0, 1);
    check("full_block", {31'b0, last_rdy}, 32'd0);
    step(1, 0, 0, 9, 1, 1, 1, 1);
    check("full_bypass_ready", {31'b0, last_rdy}, 32'd1);
    check("full_stays8", {28'b0, outstanding}, 32'd8);
    check("full_pending", pending, 32'h3FC);

    // Bogus writebacks set the sticky error only.
    step(0, 0, 0, 0, 0, 1, 0, 1);
    check("err_r0", {31'b0, wb_err}, 32'd1);
    check("err_r0_pending", pending, 32'h3FC);
    step(0, 0, 0, 0, 0, 1, 12, 1);
    check("err_r12_pending", pending, 32'h3FC);
    check("err_r12_out", {28'b0, outstanding}, 32'd8);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("err_sticky", {31'b0, wb_err}, 32'd1);

    // Register 0 never becomes busy.
    do_reset();
    step(1, 0, 0, 0, 1, 0, 0, 1);
    check("r0_ready1", {31'b0, last_rdy}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("r0_ready2", {31'b0, last_rdy}, 32'd1);
    check("r0_pending", pending, 32'h0);

`ifdef STALL_CNT_EN
    // Three stalled cycles on a RAW hazard, then reset mid-stall.
    step(1, 0, 0, 5, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 5, 0, 0, 0, 0, 0, 1);
    check("stall_3", {16'b0, stall_count}, 32'd3);
    step(1, 5, 0, 0, 0, 0, 0, 0);
    check("stall_rst", {16'b0, stall_count}, 32'd0);
    check("stall_rst_pending", pending, 32'h0);
`endif

    // Randomized traffic; small index range and frequent writebacks of busy registers.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] a, b, d, wr;
      bit v, we, wv, rn;
      int pick;
      v  = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) != 0);
      a  = 5'($urandom_range(0, 12));
      b  = 5'($urandom_range(0, 12));
      d  = 5'($urandom_range(0, 12));
      wv = ($urandom_range(0, 2) == 0);
      wr = 5'($urandom_range(0, 12));
      if (wv && busy_count() != 0 && $urandom_range(0, 9) != 0) begin
        pick = $urandom_range(1, busy_count());
        for (int i = 1; i < 32; i++) begin
          if (busy_m[i]) begin
            pick--;
            if (pick == 0) wr = 5'(i);
          end
        end
      end
      rn = ($urandom_range(0, 299) != 0);
      step(v, a, b, d, we, wv, wr, rn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
